// File: rtl/rv32_pkg.sv
// rv32_pkg: constants and types shared by the RV32I pipeline.
//   - ALU_* : 4-bit ALU control codes (must stay in step with the ALU decode)
//   - OPC_* : 7-bit RV32I major opcodes
//   - id_ex_payload_t : the registered contents of the ID/EX stage
//   - fwd_hit() : bypass match helper (write enabled, same rd, rd not x0)
package rv32_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic [3:0]  ctrl;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        illegal;
  } id_ex_payload_t;

  function automatic logic fwd_hit(input logic we, input logic [4:0] fwd_rd,
                                   input logic [4:0] rs_addr);
    return we && (fwd_rd == rs_addr) && (rs_addr != 5'd0);
  endfunction

endpackage

// File: rtl/alu_ctrl_gen.sv
// alu_ctrl_gen: combinational decode of opcode/funct3/funct7_5 into the ALU
// control code, the writeback enable (before the rd==x0 override) and the
// illegal-opcode flag.
//   opcode_i    [6:0]  RV32I opcode
//   funct3_i    [2:0]  funct3 field
//   funct7_5_i         instruction bit 30
//   ctrl_o      [3:0]  ALU control code
//   reg_write_o        instruction class writes rd
//   illegal_o          opcode not supported
module alu_ctrl_gen
  import rv32_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] ctrl_o,
  output logic       reg_write_o,
  output logic       illegal_o
);

  // Register/immediate ALU op mapping; sub_ok separates OP (SUB allowed)
  // from OP-IMM (bit 30 is part of the immediate for ADDI).
  function automatic logic [3:0] arith_ctrl(input logic [2:0] f3, input logic f7_5,
                                            input logic sub_ok);
    logic [3:0] c;
    c = ALU_ADD;
    case (f3)
      3'b000:  c = (f7_5 && sub_ok) ? ALU_SUB : ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLTU;
      3'b100:  c = ALU_XOR;
      3'b101:  c = f7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  c = ALU_OR;
      default: c = ALU_AND;
    endcase
    return c;
  endfunction

  always_comb begin
    ctrl_o      = ALU_ADD;
    reg_write_o = 1'b0;
    illegal_o   = 1'b0;
    case (opcode_i)
      OPC_OP: begin
        ctrl_o      = arith_ctrl(funct3_i, funct7_5_i, 1'b1);
        reg_write_o = 1'b1;
      end
      OPC_OPIMM: begin
        ctrl_o      = arith_ctrl(funct3_i, funct7_5_i, 1'b0);
        reg_write_o = 1'b1;
      end
      OPC_LOAD, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
        reg_write_o = 1'b1;
      end
      OPC_STORE: begin
        ctrl_o = ALU_ADD;
      end
      OPC_BRANCH: begin
        // funct3[2:1]: 00 BEQ/BNE, 10 BLT/BGE, 11 BLTU/BGEU
        case (funct3_i[2:1])
          2'b10:   ctrl_o = ALU_SLT;
          2'b11:   ctrl_o = ALU_SLTU;
          default: ctrl_o = ALU_SUB;
        endcase
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: single-entry ID/EX register stage feeding the ALU. Selects the
// operands by opcode, optionally bypasses rs1/rs2 from EX/MEM and MEM/WB,
// generates the ALU control code and holds it all under valid/ready.
// Build option: ID_EX_FORWARDING_EN enables the bypass muxes; without it the
// fwd_* inputs are ignored and register values are used as read.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_valid/in_ready                   decode-side handshake
//   in_pc, in_rs1_data, in_rs2_data, in_imm, in_rs*_addr, in_rd_addr,
//   in_opcode, in_funct3, in_funct7_5   decoded instruction
//   flush                               drop held and same-cycle instruction
//   fwd_mem_*, fwd_wb_*                 bypass sources (MEM has priority)
//   out_valid/out_ready                 ALU-side handshake
//   out_input_a, out_input_b, out_ctrl, out_rd_addr, out_reg_write,
//   out_illegal                         registered ALU inputs
module id_ex_stage
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rs1_addr,
  input  logic [4:0]      in_rs2_addr,
  input  logic [4:0]      in_rd_addr,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_5,
  input  logic            flush,
  input  logic            fwd_mem_we,
  input  logic [4:0]      fwd_mem_rd,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            fwd_wb_we,
  input  logic [4:0]      fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_input_a,
  output logic [XLEN-1:0] out_input_b,
  output logic [3:0]      out_ctrl,
  output logic [4:0]      out_rd_addr,
  output logic            out_reg_write,
  output logic            out_illegal
);

  logic            valid_q, valid_d;
  id_ex_payload_t  payload_q, payload_d;
  logic            accept;
  logic            load;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] op_a, op_b;
  logic [3:0]      ctrl;
  logic            reg_write_raw;
  logic            illegal;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // An instruction accepted in the flush cycle is discarded, not loaded.
  assign load     = accept && !flush;

`ifdef ID_EX_FORWARDING_EN
  always_comb begin
    rs1_val = in_rs1_data;
    if (fwd_hit(fwd_mem_we, fwd_mem_rd, in_rs1_addr))
      rs1_val = fwd_mem_data;
    else if (fwd_hit(fwd_wb_we, fwd_wb_rd, in_rs1_addr))
      rs1_val = fwd_wb_data;
  end

  always_comb begin
    rs2_val = in_rs2_data;
    if (fwd_hit(fwd_mem_we, fwd_mem_rd, in_rs2_addr))
      rs2_val = fwd_mem_data;
    else if (fwd_hit(fwd_wb_we, fwd_wb_rd, in_rs2_addr))
      rs2_val = fwd_wb_data;
  end
`else
  assign rs1_val = in_rs1_data;
  assign rs2_val = in_rs2_data;

  logic unused_fwd;
  assign unused_fwd = ^{fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                        fwd_wb_we, fwd_wb_rd, fwd_wb_data,
                        in_rs1_addr, in_rs2_addr};
`endif

  alu_ctrl_gen u_alu_ctrl_gen (
    .opcode_i    (in_opcode),
    .funct3_i    (in_funct3),
    .funct7_5_i  (in_funct7_5),
    .ctrl_o      (ctrl),
    .reg_write_o (reg_write_raw),
    .illegal_o   (illegal)
  );

  // Unknown opcodes fall to the default: both operands zero.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (in_opcode)
      OPC_OP, OPC_BRANCH: begin
        op_a = rs1_val;
        op_b = rs2_val;
      end
      OPC_OPIMM, OPC_LOAD, OPC_STORE: begin
        op_a = rs1_val;
        op_b = in_imm;
      end
      OPC_LUI: begin
        op_b = in_imm;
      end
      OPC_AUIPC: begin
        op_a = in_pc;
        op_b = in_imm;
      end
      OPC_JAL, OPC_JALR: begin
        op_a = in_pc;
        op_b = XLEN'(4);
      end
      default: begin
        op_a = '0;
        op_b = '0;
      end
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    if (load)
      valid_d = 1'b1;
    else if (out_ready && valid_q)
      valid_d = 1'b0;
    if (flush)
      valid_d = 1'b0;
  end

  always_comb begin
    payload_d = payload_q;
    if (load) begin
      payload_d.input_a   = op_a;
      payload_d.input_b   = op_b;
      payload_d.ctrl      = ctrl;
      payload_d.rd_addr   = in_rd_addr;
      payload_d.reg_write = reg_write_raw && (in_rd_addr != 5'd0);
      payload_d.illegal   = illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q             <= 1'b0;
      payload_q.input_a   <= '0;
      payload_q.input_b   <= '0;
      payload_q.ctrl      <= ALU_ADD;
      payload_q.rd_addr   <= '0;
      payload_q.reg_write <= 1'b0;
      payload_q.illegal   <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_input_a   = payload_q.input_a;
  assign out_input_b   = payload_q.input_b;
  assign out_ctrl      = payload_q.ctrl;
  assign out_rd_addr   = payload_q.rd_addr;
  assign out_reg_write = payload_q.reg_write;
  assign out_illegal   = payload_q.illegal;

endmodule
